mac_vec: RTL and testbench

Parametrised, pipelined multiply-accumulate engine that computes dot products over fixed-length vectors of `LEN` sample pairs. Each accepted pair is multiplied, and the products are summed into an accumulator with optional saturation. One result is emitted per completed vector, with a one-cycle valid strobe. It is the next-generation MAC for the datapath: it adds configurable widths, signed mode, vector framing, back-to-back vectors with no bubbles, and overflow reporting.

---
 rtl/mac_vec.sv | 102 ++++++++++
 tb/tb_mac_vec.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_vec.sv
// Two-stage pipelined vector multiply-accumulate: stage 1 forms the product and
// frames it, stage 2 accumulates with overflow detection and emits one result per vector.
module mac_vec #(
  parameter int DW     = 8,
  parameter int AW     = 24,
  parameter int LEN    = 16,
  parameter int SIGNED = 0,
  parameter int SAT    = 1,
  localparam int IW    = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic          clk,
  input  logic          sclr,
  input  logic          in_valid,
  input  logic [DW-1:0] ina,
  input  logic [DW-1:0] inb,
  output logic [AW-1:0] out,
  output logic          out_valid,
  output logic          ovf,
  output logic [IW-1:0] idx
);

  logic [2*DW-1:0] a_ext, b_ext, mult, prod;
  logic            p_valid, p_first, p_last, idx_last;
  logic [AW-1:0]   ext, base, raw, sat_val, sum, acc;
  logic [AW:0]     wide;
  logic            this_ovf, vovf, vovf_next;

  // Operand extension to 2*DW makes a plain multiply give the right low bits in both modes
  always_comb begin
    if (SIGNED != 0) begin
      a_ext = {{DW{ina[DW-1]}}, ina};
      b_ext = {{DW{inb[DW-1]}}, inb};
    end else begin
      a_ext = {{DW{1'b0}}, ina};
      b_ext = {{DW{1'b0}}, inb};
    end
    mult     = a_ext * b_ext;
    idx_last = (idx == IW'(LEN - 1));
  end

  // Stage 1: product register, vector framing and sample index
  always_ff @(posedge clk) begin
    if (sclr) begin
      idx     <= {IW{1'b0}};
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
      prod    <= {(2*DW){1'b0}};
    end else begin
      p_valid <= in_valid;
      if (in_valid) begin
        prod    <= mult;
        p_first <= (idx == {IW{1'b0}});
        p_last  <= idx_last;
        idx     <= idx_last ? {IW{1'b0}} : idx + IW'(1);
      end
    end
  end

  // Stage 2 datapath: first element loads instead of adding, so vectors never interact
  always_comb begin
    if (SIGNED != 0) begin
      ext = AW'($signed(prod));
    end else begin
      ext = AW'(prod);
    end
    base = p_first ? {AW{1'b0}} : acc;
    wide = {1'b0, base} + {1'b0, ext};
    raw  = wide[AW-1:0];
    if (SIGNED != 0) begin
      this_ovf = (base[AW-1] == ext[AW-1]) && (raw[AW-1] != base[AW-1]);
      sat_val  = base[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end else begin
      this_ovf = wide[AW];
      sat_val  = {AW{1'b1}};
    end
    sum       = ((SAT != 0) && this_ovf) ? sat_val : raw;
    vovf_next = p_first ? this_ovf : (vovf | this_ovf);
  end

  // Stage 2 registers: accumulator, per-vector overflow and the result outputs
  always_ff @(posedge clk) begin
    if (sclr) begin
      acc       <= {AW{1'b0}};
      vovf      <= 1'b0;
      out       <= {AW{1'b0}};
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= p_valid && p_last;
      if (p_valid) begin
        acc  <= sum;
        vovf <= vovf_next;
        if (p_last) begin
          out <= sum;
          ovf <= vovf_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_vec.sv
// Drives five differently configured mac_vec instances with shared directed stimulus and
// checks every cycle against an integer-arithmetic model plus hand-computed results.
module tb_mac_vec;
  localparam int N = 5;
  localparam int AWS [0:N-1] = '{24, 16, 16, 16, 24};
  localparam int LENS[0:N-1] = '{4, 4, 4, 4, 1};
  localparam int SGNS[0:N-1] = '{0, 0, 0, 1, 0};
  localparam int SATS[0:N-1] = '{1, 1, 0, 1, 1};

  logic clk = 1'b0;
  logic sclr = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] ina = 8'd0, inb = 8'd0;
  logic [23:0] o0, o4;
  logic [15:0] o1, o2, o3;
  logic [N-1:0] ov, ok;
  logic [1:0] x0, x1, x2, x3;
  logic x4;
  longint dout[N];
  int didx[N];

  int n_chk = 0, n_fail = 0;
  int cnt[N];
  longint acc[N], pout[N], eout[N];
  bit vovf[N], pv[N], povf[N], ev[N], eovf[N];
  bit started = 1'b0;

  always #5 clk = ~clk;

  mac_vec #(.DW(8), .AW(24), .LEN(4), .SIGNED(0), .SAT(1)) u0 (.clk(clk), .sclr(sclr), .in_valid(in_valid),
    .ina(ina), .inb(inb), .out(o0), .out_valid(ov[0]), .ovf(ok[0]), .idx(x0));
  mac_vec #(.DW(8), .AW(16), .LEN(4), .SIGNED(0), .SAT(1)) u1 (.clk(clk), .sclr(sclr), .in_valid(in_valid),
    .ina(ina), .inb(inb), .out(o1), .out_valid(ov[1]), .ovf(ok[1]), .idx(x1));
  mac_vec #(.DW(8), .AW(16), .LEN(4), .SIGNED(0), .SAT(0)) u2 (.clk(clk), .sclr(sclr), .in_valid(in_valid),
    .ina(ina), .inb(inb), .out(o2), .out_valid(ov[2]), .ovf(ok[2]), .idx(x2));
  mac_vec #(.DW(8), .AW(16), .LEN(4), .SIGNED(1), .SAT(1)) u3 (.clk(clk), .sclr(sclr), .in_valid(in_valid),
    .ina(ina), .inb(inb), .out(o3), .out_valid(ov[3]), .ovf(ok[3]), .idx(x3));
  mac_vec #(.DW(8), .AW(24), .LEN(1), .SIGNED(0), .SAT(1)) u4 (.clk(clk), .sclr(sclr), .in_valid(in_valid),
    .ina(ina), .inb(inb), .out(o4), .out_valid(ov[4]), .ovf(ok[4]), .idx(x4));

  assign dout[0] = longint'(o0);
  assign dout[1] = longint'(o1);
  assign dout[2] = longint'(o2);
  assign dout[3] = longint'(o3);
  assign dout[4] = longint'(o4);
  assign didx[0] = int'(x0);
  assign didx[1] = int'(x1);
  assign didx[2] = int'(x2);
  assign didx[3] = int'(x3);
  assign didx[4] = int'(x4);

  function automatic longint msk(longint v, int aw);
    return v & ((64'sd1 <<< aw) - 64'sd1);
  endfunction

  task automatic chk(string name, int inst, longint act, longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d got=%0d expected=%0d at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Reference: true integer sum checked against the representable range of each config
  task automatic model_step();
    longint p, s, lo, hi, m;
    bit o, first;
    started = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (sclr) begin
        cnt[i] = 0; acc[i] = 0; vovf[i] = 0; pv[i] = 0;
        ev[i] = 0; eout[i] = 0; eovf[i] = 0;
      end else begin
        ev[i] = pv[i];
        if (pv[i]) begin
          eout[i] = pout[i];
          eovf[i] = povf[i];
        end
        pv[i] = 0;
        if (in_valid) begin
          if (SGNS[i] != 0) p = longint'($signed(ina)) * longint'($signed(inb));
          else p = longint'(ina) * longint'(inb);
          first = (cnt[i] == 0);
          s = (first ? 64'sd0 : acc[i]) + p;
          m = 64'sd1 <<< AWS[i];
          lo = (SGNS[i] != 0) ? -(m / 2) : 64'sd0;
          hi = (SGNS[i] != 0) ? (m / 2) - 1 : m - 1;
          o = (s < lo) || (s > hi);
          if (o) begin
            if (SATS[i] != 0) s = (s < lo) ? lo : hi;
            else begin
              s = s & (m - 1);
              if (SGNS[i] != 0 && s >= m / 2) s = s - m;
            end
          end
          acc[i] = s;
          vovf[i] = first ? o : (vovf[i] | o);
          cnt[i]++;
          if (cnt[i] == LENS[i]) begin
            cnt[i] = 0;
            pv[i] = 1;
            pout[i] = acc[i];
            povf[i] = vovf[i];
          end
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < N; i++) begin
        chk("out_valid", i, longint'(ov[i]), longint'(ev[i]));
        chk("out", i, dout[i], msk(eout[i], AWS[i]));
        chk("ovf", i, longint'(ok[i]), longint'(eovf[i]));
        chk("idx", i, longint'(didx[i]), longint'(cnt[i]));
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1; ina = a; inb = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    idle(2);
    chk("rst_out", 0, longint'(o0), 64'sd0);
    chk("rst_valid", 0, longint'(ov), 64'sd0);
    chk("rst_idx", 0, longint'(x0), 64'sd0);
    sclr = 1'b0;
    idle(1);
    // basic vector, then back-to-back vector of 255s with a 3-cycle gap
    send(8'd1, 8'd2); send(8'd3, 8'd4); send(8'd5, 8'd6); send(8'd7, 8'd8);
    send(8'd255, 8'd255);
    chk("basic_valid", 0, longint'(ov[0]), 64'sd1);
    chk("basic_out", 0, longint'(o0), 64'sd100);
    chk("basic_ovf", 0, longint'(ok[0]), 64'sd0);
    chk("model_basic", 0, eout[0], 64'sd100);
    send(8'd255, 8'd255);
    idle(3);
    send(8'd255, 8'd255); send(8'd255, 8'd255);
    idle(1);
    chk("b2b_out", 0, longint'(o0), 64'sd260100);
    chk("b2b_ovf", 0, longint'(ok[0]), 64'sd0);
    chk("sat_out", 1, longint'(o1), 64'sd65535);
    chk("sat_ovf", 1, longint'(ok[1]), 64'sd1);
    chk("wrap_out", 2, longint'(o2), 64'sd63492);
    chk("wrap_ovf", 2, longint'(ok[2]), 64'sd1);
    chk("model_wrap", 2, eout[2], 64'sd63492);
    repeat (4) send(8'd1, 8'd1);
    idle(1);
    chk("ones_sat", 1, longint'(o1), 64'sd4);
    chk("ones_sat_ovf", 1, longint'(ok[1]), 64'sd0);
    chk("ones_wrap", 2, longint'(o2), 64'sd4);
    chk("ones_wrap_ovf", 2, longint'(ok[2]), 64'sd0);
    // signed: (-128 * 127) x4 saturates negative, then (-2 * 3) x4
    repeat (4) send(8'h80, 8'h7F);
    idle(1);
    chk("sgn_sat_out", 3, longint'(o3), 64'sh8000);
    chk("sgn_sat_ovf", 3, longint'(ok[3]), 64'sd1);
    chk("model_sgn", 3, eout[3], -64'sd32768);
    repeat (4) send(8'hFE, 8'h03);
    idle(1);
    chk("sgn_out", 3, longint'(o3), 64'shFFE8);
    chk("sgn_ovf", 3, longint'(ok[3]), 64'sd0);
    // reset mid-vector with a sample presented alongside sclr
    send(8'd9, 8'd9); send(8'd9, 8'd9);
    sclr = 1'b1; in_valid = 1'b1; ina = 8'd9; inb = 8'd9;
    @(posedge clk); #1;
    sclr = 1'b0; in_valid = 1'b0;
    chk("mid_rst_out", 0, longint'(o0), 64'sd0);
    chk("mid_rst_valid", 0, longint'(ov), 64'sd0);
    chk("mid_rst_idx", 0, longint'(x0), 64'sd0);
    idle(1);
    chk("post_rst_valid", 0, longint'(ov), 64'sd0);
    repeat (4) send(8'd1, 8'd1);
    idle(1);
    chk("after_rst_valid", 0, longint'(ov[0]), 64'sd1);
    chk("after_rst_out", 0, longint'(o0), 64'sd4);
    // LEN=1: each sample is a full vector
    send(8'd2, 8'd3); send(8'd4, 8'd5);
    chk("len1_v0", 4, longint'(ov[4]), 64'sd1);
    chk("len1_out0", 4, longint'(o4), 64'sd6);
    idle(1);
    chk("len1_v1", 4, longint'(ov[4]), 64'sd1);
    chk("len1_out1", 4, longint'(o4), 64'sd20);
    idle(1);
    chk("len1_v2", 4, longint'(ov[4]), 64'sd0);
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
